accumulator_scheduler: RTL and testbench

//   Sequences one result-collection job between the systolic-array output column and the unified buffer.
//   On start it captures NUM results from the array into a DEPTH-entry result bank, then drains them to the

---
 rtl/accumulator_scheduler.sv | 122 ++++++++++++
 tb/tb_accumulator_scheduler.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accumulator_scheduler.sv
// rtl/accumulator_scheduler.sv - collects NUM array results into a bank, then drains them to the unified buffer
// Optional feature macro ACC_SCHED_ADD_EN: acc_mode=1 accumulates into the bank instead of overwriting.
module accumulator_scheduler #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [$clog2(DEPTH):0]  num_entries,
   input  logic [ADDR_W-1:0]       base_addr,
   input  logic                    acc_mode,
   input  logic                    in_valid,
   input  logic [DATA_W-1:0]       in_data,
   output logic                    in_ready,
   output logic                    out_valid,
   output logic [DATA_W-1:0]       out_data,
   output logic [ADDR_W-1:0]       out_addr,
   input  logic                    out_ready,
   output logic                    busy,
   output logic                    done,
   output logic                    overflow
);

   localparam int NUM_W = $clog2(DEPTH) + 1;
   localparam int IDX_W = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;

   state_t              state, next_state;
   logic [DATA_W-1:0]   bank [DEPTH];
   logic [NUM_W-1:0]    num_q, wr_idx, rd_idx, num_clamped;
   logic [ADDR_W-1:0]   base_q;
   logic [DATA_W-1:0]   wr_data;
   logic                start_acc, beat, xfer, last_beat, last_xfer;

   assign num_clamped = (num_entries > NUM_W'(DEPTH)) ? NUM_W'(DEPTH) : num_entries;
   assign start_acc   = start && (state == IDLE);
   assign beat        = in_valid && (state == COLLECT);
   assign xfer        = out_ready && (state == DRAIN);
   assign last_beat   = beat && (wr_idx == num_q - 1'b1);
   assign last_xfer   = xfer && (rd_idx == num_q - 1'b1);

`ifdef ACC_SCHED_ADD_EN
   logic acc_q;
   assign wr_data = acc_q ? bank[wr_idx[IDX_W-1:0]] + in_data : in_data;
`else
   logic acc_mode_unused;
   assign acc_mode_unused = acc_mode;
   assign wr_data         = in_data;
`endif

   // Drain outputs read the bank directly so they hold while the buffer stalls.
   assign out_data = (state == DRAIN) ? bank[rd_idx[IDX_W-1:0]] : '0;
   assign out_addr = (state == DRAIN) ? base_q + ADDR_W'(rd_idx) : '0;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      busy       = 1'b1;
      done       = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) next_state = (num_clamped == '0) ? DONE : COLLECT;
         end
         COLLECT: begin
            in_ready = 1'b1;
            if (last_beat) next_state = DRAIN;
         end
         DRAIN: begin
            out_valid = 1'b1;
            if (last_xfer) next_state = DONE;
         end
         DONE: begin
            done       = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) bank[i] <= '0;
         num_q    <= '0;
         base_q   <= '0;
         wr_idx   <= '0;
         rd_idx   <= '0;
         overflow <= 1'b0;
`ifdef ACC_SCHED_ADD_EN
         acc_q    <= 1'b0;
`endif
      end else begin
         if (start_acc) begin
            num_q    <= num_clamped;
            base_q   <= base_addr;
            wr_idx   <= '0;
            rd_idx   <= '0;
            overflow <= 1'b0;
`ifdef ACC_SCHED_ADD_EN
            acc_q    <= acc_mode;
`endif
         end
         if (beat) begin
            bank[wr_idx[IDX_W-1:0]] <= wr_data;
            wr_idx                  <= wr_idx + 1'b1;
         end
         if (xfer) rd_idx <= rd_idx + 1'b1;
         // A dropped beat wins over the clear from a simultaneous start.
         if (in_valid && (state != COLLECT)) overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_accumulator_scheduler.sv
// tb/tb_accumulator_scheduler.sv - directed self-checking bench for accumulator_scheduler
module tb_accumulator_scheduler;

   localparam int DATA_W = 32;
   localparam int DEPTH  = 4;
   localparam int ADDR_W = 8;

   logic              clk = 1'b0;
   logic              reset, start, acc_mode, in_valid, out_ready;
   logic [2:0]        num_entries;
   logic [ADDR_W-1:0] base_addr;
   logic [DATA_W-1:0] in_data;
   logic              in_ready, out_valid, busy, done, overflow;
   logic [DATA_W-1:0] out_data;
   logic [ADDR_W-1:0] out_addr;

   int checks = 0;
   int errors = 0;

   logic [ADDR_W-1:0] q_addr [$];
   logic [DATA_W-1:0] q_data [$];
   int                last_xfer_cyc, done_cyc;

   accumulator_scheduler #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .reset(reset), .start(start), .num_entries(num_entries),
      .base_addr(base_addr), .acc_mode(acc_mode), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_addr(out_addr),
      .out_ready(out_ready), .busy(busy), .done(done), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_job(input int n, input logic [ADDR_W-1:0] b, input logic m);
      start = 1'b1; num_entries = 3'(n); base_addr = b; acc_mode = m;
      step();
      start = 1'b0;
   endtask

   task automatic feed(input logic [DATA_W-1:0] d);
      in_valid = 1'b1; in_data = d;
      step();
      in_valid = 1'b0;
   endtask

   // Records every transfer until done; leaves the DUT back in IDLE.
   task automatic capture(input logic [3:0] pat, output bit got_done);
      q_addr.delete(); q_data.delete();
      got_done = 1'b0; last_xfer_cyc = -10; done_cyc = -1;
      for (int c = 0; c < 40; c++) begin
         out_ready = pat[c % 4];
         #1;
         if (done) begin
            got_done = 1'b1; done_cyc = c;
            break;
         end
         if (out_valid && out_ready) begin
            q_addr.push_back(out_addr); q_data.push_back(out_data); last_xfer_cyc = c;
         end
         @(posedge clk);
         #1;
      end
      out_ready = 1'b0;
      step();
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 0; num_entries = 0; base_addr = 0; acc_mode = 0;
      in_valid = 0; in_data = 0; out_ready = 0;
      repeat (2) step();
      reset = 1'b0;
      #1;
      checks++;
      if ({in_ready, out_valid, busy, done, overflow} !== 5'b0 || out_data !== '0 || out_addr !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got flags=%b data=%h addr=%h required all zero",
                  {in_ready, out_valid, busy, done, overflow}, out_data, out_addr);
      end
   endtask

   task automatic test_basic();
      bit gd;
      start_job(2, 8'h10, 1'b0);
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b1) begin
         errors++; $display("FAIL basic_collect: in_ready=%b busy=%b required 1 1", in_ready, busy);
      end
      feed(32'd7);
      feed(32'd0);
      checks++;
      if (out_valid !== 1'b1) begin
         errors++; $display("FAIL basic_latency: out_valid=%b required 1", out_valid);
      end
      capture(4'hF, gd);
      checks++;
      if (!gd) begin errors++; $display("FAIL basic_done: got timeout required done pulse"); end
      checks++;
      if (q_addr.size() != 2) begin
         errors++; $display("FAIL basic_count: got %0d required 2", q_addr.size());
      end else begin
         checks++;
         if (q_addr[0] !== 8'h10 || q_data[0] !== 32'd7 || q_addr[1] !== 8'h11 || q_data[1] !== 32'd0) begin
            errors++;
            $display("FAIL basic_words: got (%h,%h)(%h,%h) required (10,7)(11,0)",
                     q_addr[0], q_data[0], q_addr[1], q_data[1]);
         end
      end
      checks++;
      if (done_cyc != last_xfer_cyc + 1) begin
         errors++; $display("FAIL basic_done_timing: done at %0d required %0d", done_cyc, last_xfer_cyc + 1);
      end
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++; $display("FAIL basic_idle: busy=%b done=%b required 0 0", busy, done);
      end
   endtask

   task automatic test_backpressure();
      logic [3:0]        pat = 4'b1001;
      logic [ADDR_W-1:0] pa;
      logic [DATA_W-1:0] pd;
      bit                stalled = 0, gd = 0;
      int                n = 0;
      start_job(4, 8'h20, 1'b0);
      for (int i = 1; i <= 4; i++) feed(32'(i));
      for (int c = 0; c < 40; c++) begin
         out_ready = pat[c % 4];
         #1;
         if (done) begin gd = 1; break; end
         if (out_valid && stalled) begin
            checks++;
            if (out_addr !== pa || out_data !== pd) begin
               errors++;
               $display("FAIL bp_stable: got (%h,%h) required (%h,%h)", out_addr, out_data, pa, pd);
            end
         end
         if (out_valid && out_ready) begin
            checks++;
            if (out_addr !== 8'(8'h20 + n) || out_data !== 32'(n + 1)) begin
               errors++;
               $display("FAIL bp_word%0d: got (%h,%h) required (%h,%h)", n, out_addr, out_data,
                        8'(8'h20 + n), 32'(n + 1));
            end
            n++;
            stalled = 0;
         end else if (out_valid) begin
            stalled = 1; pa = out_addr; pd = out_data;
         end
         @(posedge clk);
         #1;
      end
      out_ready = 1'b0;
      step();
      checks++;
      if (!gd || n != 4) begin
         errors++; $display("FAIL bp_count: got %0d transfers done=%b required 4 done=1", n, gd);
      end
   endtask

   task automatic test_overflow();
      bit gd;
      start_job(2, 8'h00, 1'b0);
      feed(32'hA);
      feed(32'hB);
      out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hDEAD;
      start = 1'b1; num_entries = 3'd1; base_addr = 8'h50;
      step();
      in_valid = 1'b0; start = 1'b0;
      checks++;
      if (overflow !== 1'b1 || busy !== 1'b1) begin
         errors++; $display("FAIL ovf_set: overflow=%b busy=%b required 1 1", overflow, busy);
      end
      checks++;
      if (out_addr !== 8'h00 || out_data !== 32'hA) begin
         errors++; $display("FAIL ovf_start_ignored: got (%h,%h) required (00,0000000a)", out_addr, out_data);
      end
      capture(4'hF, gd);
      checks++;
      if (!gd || q_addr.size() != 2) begin
         errors++; $display("FAIL ovf_drain_count: got %0d done=%b required 2 done=1", q_addr.size(), gd);
      end else begin
         checks++;
         if (q_data[0] !== 32'hA || q_data[1] !== 32'hB || q_addr[1] !== 8'h01) begin
            errors++; $display("FAIL ovf_bank: got %h,%h@%h required a,b@01", q_data[0], q_data[1], q_addr[1]);
         end
      end
      checks++;
      if (overflow !== 1'b1) begin
         errors++; $display("FAIL ovf_sticky: got %b required 1", overflow);
      end
      start_job(1, 8'h60, 1'b0);
      checks++;
      if (overflow !== 1'b0) begin
         errors++; $display("FAIL ovf_clear: got %b required 0", overflow);
      end
      feed(32'h5);
      capture(4'hF, gd);
   endtask

   task automatic test_edges();
      bit gd;
      start_job(0, 8'h33, 1'b0);
      checks++;
      if (done !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
         errors++; $display("FAIL num0_done: done=%b out_valid=%b in_ready=%b required 1 0 0",
                            done, out_valid, in_ready);
      end
      step();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL num0_idle: done=%b busy=%b required 0 0", done, busy);
      end
      start_job(7, 8'h00, 1'b0);
      for (int i = 0; i < 4; i++) feed(32'h11 + 32'(i));
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
         errors++; $display("FAIL clamp_drain: out_valid=%b in_ready=%b required 1 0", out_valid, in_ready);
      end
      capture(4'hF, gd);
      checks++;
      if (!gd || q_data.size() != 4) begin
         errors++; $display("FAIL clamp_count: got %0d required 4", q_data.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (q_data[i] !== 32'h11 + 32'(i) || q_addr[i] !== 8'(i)) begin
               errors++; $display("FAIL clamp_word%0d: got (%h,%h) required (%h,%h)", i, q_addr[i], q_data[i],
                                  8'(i), 32'h11 + 32'(i));
            end
         end
      end
      start_job(2, 8'hFF, 1'b0);
      feed(32'h1);
      feed(32'h2);
      capture(4'hF, gd);
      checks++;
      if (q_addr.size() != 2 || q_addr[0] !== 8'hFF || q_addr[1] !== 8'h00) begin
         errors++; $display("FAIL addr_wrap: got %0d words first=%h required 2 words ff,00", q_addr.size(), q_addr[0]);
      end
   endtask

   task automatic test_reset_mid();
      bit gd;
      start_job(3, 8'h30, 1'b0);
      feed(32'h9);
      reset = 1'b1;
      step();
      reset = 1'b0;
      checks++;
      if ({in_ready, out_valid, busy, done, overflow} !== 5'b0 || out_data !== '0 || out_addr !== '0) begin
         errors++;
         $display("FAIL reset_mid: got flags=%b data=%h addr=%h required all zero",
                  {in_ready, out_valid, busy, done, overflow}, out_data, out_addr);
      end
      start_job(1, 8'h40, 1'b0);
      feed(32'h5);
      capture(4'hF, gd);
      checks++;
      if (!gd || q_addr.size() != 1 || q_addr[0] !== 8'h40 || q_data[0] !== 32'h5) begin
         errors++; $display("FAIL reset_recover: got %0d words (%h,%h) required 1 word (40,5)",
                            q_addr.size(), q_addr[0], q_data[0]);
      end
   endtask

   task automatic test_accumulate();
      bit                gd;
      logic [DATA_W-1:0] e0, e1;
`ifdef ACC_SCHED_ADD_EN
      e0 = 32'd13; e1 = 32'd3;
`else
      e0 = 32'd10; e1 = 32'hFFFFFFFF;
`endif
      start_job(2, 8'h00, 1'b0);
      feed(32'd3);
      feed(32'd4);
      capture(4'hF, gd);
      start_job(2, 8'h00, 1'b1);
      feed(32'd10);
      feed(32'hFFFFFFFF);
      capture(4'hF, gd);
      checks++;
      if (q_data.size() != 2 || q_data[0] !== e0 || q_data[1] !== e1) begin
         errors++; $display("FAIL accumulate: got %0d words %h,%h required %h,%h",
                            q_data.size(), q_data[0], q_data[1], e0, e1);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_overflow();
      test_edges();
      test_reset_mid();
      test_accumulate();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule
